// File: rtl/seq_signed_multiplier_if.sv
// Operand/result bundle between the controller (master) and the sequential
// signed multiplier (slave).
interface seq_signed_multiplier_if #(
    parameter int WIDTH = 16
);
    logic signed [WIDTH-1:0] mul_in1;
    logic signed [WIDTH-1:0] mul_in2;
    logic                    start_mul;
    logic signed [WIDTH-1:0] mul_out;
    logic                    mul_finish;
    logic                    overflow;
    logic                    busy;

    modport master (
        output mul_in1, mul_in2, start_mul,
        input  mul_out, mul_finish, overflow, busy
    );

    modport slave (
        input  mul_in1, mul_in2, start_mul,
        output mul_out, mul_finish, overflow, busy
    );
endinterface

// File: rtl/seq_signed_multiplier.sv
// Sign-magnitude shift-add signed multiplier, one multiplier bit per cycle.
// Define MUL_SATURATE_EN to clamp mul_out on overflow instead of wrapping.
module seq_signed_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    seq_signed_multiplier_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W  = (2*WIDTH)'(1);
    localparam logic [CW-1:0]      LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand_sh;
    logic [WIDTH-1:0]   mplier;
    logic               neg;

    logic [WIDTH-1:0]   mul_out_q;
    logic               mul_finish_q;
    logic               overflow_q;
    logic               busy_q;

    // Operand magnitudes as unsigned values so the most negative input is exact.
    logic [WIDTH-1:0] in1_u;
    logic [WIDTH-1:0] in2_u;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign in1_u = bus.mul_in1;
    assign in2_u = bus.mul_in2;
    assign mag_a = in1_u[WIDTH-1] ? (~in1_u + ONE_W) : in1_u;
    assign mag_b = in2_u[WIDTH-1] ? (~in2_u + ONE_W) : in2_u;

    logic [2*WIDTH-1:0] prod;
    logic               prod_ovf;
    logic [WIDTH-1:0]   result;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        prod = acc;
        if (neg && (acc != '0))
            prod = ~acc + ONE_2W;

        // Fits in signed WIDTH bits only if the top WIDTH+1 bits are all copies of the sign.
        prod_ovf = !((&prod[2*WIDTH-1:WIDTH-1]) || (~|prod[2*WIDTH-1:WIDTH-1]));

`ifdef MUL_SATURATE_EN
        result = prod[WIDTH-1:0];
        if (prod_ovf)
            result = prod[2*WIDTH-1] ? SAT_MIN : SAT_MAX;
`else
        result = prod[WIDTH-1:0];
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            acc          <= '0;
            mcand_sh     <= '0;
            mplier       <= '0;
            neg          <= 1'b0;
            mul_out_q    <= '0;
            mul_finish_q <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            mul_finish_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start_mul) begin
                        mcand_sh <= {{WIDTH{1'b0}}, mag_a};
                        mplier   <= mag_b;
                        neg      <= in1_u[WIDTH-1] ^ in2_u[WIDTH-1];
                        acc      <= '0;
                        count    <= '0;
                        busy_q   <= 1'b1;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    if (mplier[0])
                        acc <= acc + mcand_sh;
                    mcand_sh <= mcand_sh << 1;
                    mplier   <= mplier >> 1;
                    count    <= count + 1'b1;
                    if (count == LAST)
                        state <= FINISH;
                end

                FINISH: begin
                    mul_out_q    <= result;
                    overflow_q   <= prod_ovf;
                    mul_finish_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state        <= IDLE;
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mul_out    = mul_out_q;
    assign bus.mul_finish = mul_finish_q;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Directed bench for seq_signed_multiplier; expected mul_out values follow
// MUL_SATURATE_EN the same way the design does.
module tb_seq_signed_multiplier;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    logic [15:0] last_out;
    logic        last_ovf;

    seq_signed_multiplier_if #(.WIDTH(16)) bus ();

    seq_signed_multiplier #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, observed, expected);
        end
    endtask

    // Start at E0, step through E1..E16, check the pulse at E17 and its drop at E18.
    task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_out, input logic exp_ovf);
        bus.mul_in1   = a;
        bus.mul_in2   = b;
        bus.start_mul = 1'b1;
        tick();
        bus.start_mul = 1'b0;
        bus.mul_in1   = 16'h1234;
        bus.mul_in2   = 16'h0F0F;
        check({tag, " busy@E0"}, {15'd0, bus.busy}, 16'd1);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check({tag, " busy@run"}, {15'd0, bus.busy}, 16'd1);
            check({tag, " finish@run"}, {15'd0, bus.mul_finish}, 16'd0);
            check({tag, " out held@run"}, bus.mul_out, last_out);
            check({tag, " ovf held@run"}, {15'd0, bus.overflow}, {15'd0, last_ovf});
        end
        tick();
        check({tag, " finish@E17"}, {15'd0, bus.mul_finish}, 16'd1);
        check({tag, " busy@E17"}, {15'd0, bus.busy}, 16'd0);
        check({tag, " mul_out"}, bus.mul_out, exp_out);
        check({tag, " overflow"}, {15'd0, bus.overflow}, {15'd0, exp_ovf});
        tick();
        check({tag, " finish@E18"}, {15'd0, bus.mul_finish}, 16'd0);
        check({tag, " out held@E18"}, bus.mul_out, exp_out);
        last_out = exp_out;
        last_ovf = exp_ovf;
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        last_out      = 16'h0000;
        last_ovf      = 1'b0;
        reset         = 1'b0;
        bus.mul_in1   = 16'h0000;
        bus.mul_in2   = 16'h0000;
        bus.start_mul = 1'b0;

        tick();
        tick();
        check("reset mul_out", bus.mul_out, 16'h0000);
        check("reset finish", {15'd0, bus.mul_finish}, 16'd0);
        check("reset overflow", {15'd0, bus.overflow}, 16'd0);
        check("reset busy", {15'd0, bus.busy}, 16'd0);
        reset = 1'b1;
        tick();

        do_mul("23x45", 16'd23, 16'd45, 16'h040B, 1'b0);
        do_mul("-7x6", 16'hFFF9, 16'd6, 16'hFFD6, 1'b0);
        do_mul("-32768x1", 16'h8000, 16'd1, 16'h8000, 1'b0);
        do_mul("-1x-1", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0);
        do_mul("0x-5", 16'd0, 16'hFFFB, 16'h0000, 1'b0);
`ifdef MUL_SATURATE_EN
        do_mul("300x300", 16'd300, 16'd300, 16'h7FFF, 1'b1);
        do_mul("-32768x-1", 16'h8000, 16'hFFFF, 16'h7FFF, 1'b1);
        do_mul("-300x300", 16'hFED4, 16'd300, 16'h8000, 1'b1);
`else
        do_mul("300x300", 16'd300, 16'd300, 16'h5F90, 1'b1);
        do_mul("-32768x-1", 16'h8000, 16'hFFFF, 16'h8000, 1'b1);
        do_mul("-300x300", 16'hFED4, 16'd300, 16'hA070, 1'b1);
`endif

        // Starts at E4 and E17 are ignored; the start held at E18 is accepted.
        bus.mul_in1   = 16'd100;
        bus.mul_in2   = 16'd3;
        bus.start_mul = 1'b1;
        tick();
        bus.start_mul = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            if (e == 4 || e == 16) begin
                bus.mul_in1   = 16'd5;
                bus.mul_in2   = 16'd5;
                bus.start_mul = 1'b1;
            end
            tick();
            bus.start_mul = 1'b0;
            check("ign finish@run", {15'd0, bus.mul_finish}, 16'd0);
            check("ign busy@run", {15'd0, bus.busy}, 16'd1);
        end
        bus.start_mul = 1'b1;
        tick();
        check("ign finish@E17", {15'd0, bus.mul_finish}, 16'd1);
        check("ign mul_out 300", bus.mul_out, 16'd300);
        tick();
        bus.start_mul = 1'b0;
        check("b2b finish@E18", {15'd0, bus.mul_finish}, 16'd0);
        check("b2b busy@E18", {15'd0, bus.busy}, 16'd1);
        for (int e = 19; e <= 34; e++) begin
            tick();
            check("b2b finish early", {15'd0, bus.mul_finish}, 16'd0);
            check("b2b out held", bus.mul_out, 16'd300);
        end
        tick();
        check("b2b finish@E35", {15'd0, bus.mul_finish}, 16'd1);
        check("b2b mul_out 25", bus.mul_out, 16'd25);
        tick();

        // Reset mid-operation clears outputs at once and abandons the operation.
        bus.mul_in1   = 16'd100;
        bus.mul_in2   = 16'd3;
        bus.start_mul = 1'b1;
        tick();
        bus.start_mul = 1'b0;
        for (int e = 1; e <= 7; e++) tick();
        check("pre-reset busy", {15'd0, bus.busy}, 16'd1);
        check("pre-reset out", bus.mul_out, 16'd25);
        #3;
        reset = 1'b0;
        #1;
        check("async mul_out", bus.mul_out, 16'h0000);
        check("async busy", {15'd0, bus.busy}, 16'd0);
        check("async finish", {15'd0, bus.mul_finish}, 16'd0);
        check("async overflow", {15'd0, bus.overflow}, 16'd0);
        tick();
        reset = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick();
            check("abandoned finish", {15'd0, bus.mul_finish}, 16'd0);
            check("abandoned busy", {15'd0, bus.busy}, 16'd0);
        end
        last_out = 16'h0000;
        last_ovf = 1'b0;
        do_mul("2x2", 16'd2, 16'd2, 16'd4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_signed_multiplier.md
Name: seq_signed_multiplier

Overview:
- Multi-cycle signed multiplier that serves the general controller's multiply path.
- Consumes the controller's operands (mul_in1, mul_in2) and its start_mul strobe.
- Returns a 16-bit product with a one-cycle mul_finish pulse and an overflow flag.
- Uses sign-magnitude shift-add, one multiplier bit per cycle. This trades latency for area, so no combinational 16x16 array is needed.

Parameters:
- WIDTH, 16, operand and result width in bits. The internal accumulator is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset; clears all state immediately when low
- mul_in1  input  WIDTH  signed two's-complement multiplicand; sampled only on an accepted start
- mul_in2  input  WIDTH  signed two's-complement multiplier; sampled only on an accepted start
- start_mul  input  1  start request; accepted only in IDLE
- mul_out  output  WIDTH  signed result; held until the next completion or reset
- mul_finish  output  1  one-cycle completion pulse
- overflow  output  1  the full product does not fit in signed WIDTH bits; valid with mul_finish and held with mul_out
- busy  output  1  high while an operation is in progress (states RUN and FINISH)

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE
  - mul_out = 0, mul_finish = 0, overflow = 0, busy = 0
  - counter and accumulator cleared
  - An operation in flight is abandoned; no mul_finish is produced for it.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start_mul = 1 at edge E0 captures both operands.
  - Magnitudes are computed as unsigned WIDTH-bit values, so |-32768| = 0x8000 is exact.
  - Result sign = XOR of the operand MSBs. Accumulator and counter are cleared.
  - Next state = RUN; busy goes high.
- RUN:
  - At each edge E1..E(WIDTH): if the current multiplier LSB = 1, add the shifted multiplicand magnitude into the 2*WIDTH accumulator; then shift and increment the counter.
  - After the WIDTH-th iteration (edge E(WIDTH)), next state = FINISH.
  - Zero operands still take the full latency.
- FINISH, at edge E(WIDTH+1):
  - Apply the sign (two's-complement negate if the result sign is 1 and the magnitude is non-zero) to get the 2*WIDTH signed product P.
  - overflow = 1 if P < -2^(WIDTH-1) or P > 2^(WIDTH-1)-1.
  - mul_out = low WIDTH bits of P, or the saturated value (see Optional Feature).
  - mul_finish = 1; next state = IDLE; busy = 0.
- Edge E(WIDTH+2): mul_finish returns to 0. With WIDTH = 16, mul_finish is high between E17 and E18.
- start_mul while in RUN or FINISH is ignored. This includes start_mul high at the E(WIDTH+1) edge.
- start_mul sampled at E(WIDTH+2) is accepted (back-to-back operation).
- start_mul held high continuously restarts an operation at every IDLE edge.
- Operand changes after E0 have no effect on the operation in progress.
- mul_out and overflow change only at the FINISH edge or on reset.

Optional Feature:
- Macro: MUL_SATURATE_EN.
- Defined: on overflow, mul_out clamps to 0x7FFF when P is positive and to 0x8000 when P is negative.
- Undefined: mul_out is always the low WIDTH bits of P (wrap-around).
- overflow is reported identically in both builds.

Test Plan:
- 23 x 45, start at E0:
  - busy high E0..E17
  - mul_out = 1035 (0x040B), mul_finish high one cycle after E17
  - overflow = 0
- -7 x 6 -> mul_out = 0xFFD6 (-42), overflow = 0.
- -32768 x 1 -> 0x8000, overflow = 0.
- 300 x 300 (P = 90000):
  - overflow = 1
  - mul_out = 0x7FFF with MUL_SATURATE_EN, 0x5F90 without
- -32768 x -1 (P = 32768):
  - overflow = 1
  - mul_out = 0x7FFF with MUL_SATURATE_EN, 0x8000 without
- Start 100 x 3:
  - Pulse start_mul with 5 x 5 at E4 and again at E17 -> both ignored; single mul_finish with mul_out = 300.
  - Start 5 x 5 at E18 -> mul_out = 25 at E35.
  - Second run: 100 x 3, assert reset low at E8 -> all outputs 0 immediately, no mul_finish.
  - Release reset, start 2 x 2 -> mul_out = 4 after the full latency.
